// File: rtl/tdm_slot_sequencer.sv
// rtl/tdm_slot_sequencer.sv - TDM slot tracker driving a 1-to-8 demux, with frame assembly and sync-lock supervision
module tdm_slot_sequencer #(
    parameter int SLOTS         = 8,
    parameter int SYNC_LOSS_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       fsync,
    output logic [2:0] SEL,
    output logic       dm_en,
    output logic       dm_in,
    output logic [7:0] frame,
    output logic       frame_valid,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);
    localparam logic [2:0] LOSS_MAX  = 3'(SYNC_LOSS_MAX);

    state_t     state, state_next;
    logic [2:0] slot, slot_next;
    logic [2:0] miss, miss_next;
    logic [7:0] shift, shift_next;
    logic [2:0] sel_next;
    logic       dm_en_next;
    logic       dm_in_next;
    logic [7:0] frame_next;
    logic       frame_valid_next;
    logic       sync_err_next;
    logic [2:0] miss_inc;

    assign miss_inc = miss + 3'd1;
    assign locked   = (state == LOCK);

    always_comb begin
        state_next       = state;
        slot_next        = slot;
        miss_next        = miss;
        shift_next       = shift;
        sel_next         = SEL;
        dm_en_next       = 1'b0;
        dm_in_next       = dm_in;
        frame_next       = frame;
        frame_valid_next = 1'b0;
        sync_err_next    = 1'b0;

        if (!en) begin
            state_next = IDLE;
            slot_next  = 3'd0;
            miss_next  = 3'd0;
            shift_next = 8'd0;
        end else begin
            case (state)
                IDLE: state_next = HUNT;
                HUNT: begin
                    if (in_valid && fsync) begin
                        state_next = LOCK;
                        sel_next   = 3'd0;
                        dm_en_next = 1'b1;
                        dm_in_next = in_bit;
                        shift_next = {7'd0, in_bit};
                        slot_next  = 3'd1;
                        miss_next  = 3'd0;
                    end
                end
                LOCK: begin
                    if (in_valid) begin
                        if (fsync && slot != 3'd0) begin
                            // Misplaced marker: restart the frame on this beat as slot 0
                            sync_err_next = 1'b1;
                            sel_next      = 3'd0;
                            dm_en_next    = 1'b1;
                            dm_in_next    = in_bit;
                            shift_next    = {7'd0, in_bit};
                            slot_next     = 3'd1;
                            miss_next     = 3'd0;
                        end else if (slot == 3'd0 && !fsync && miss_inc == LOSS_MAX) begin
                            state_next = HUNT;
                            slot_next  = 3'd0;
                            miss_next  = 3'd0;
                            shift_next = 8'd0;
                        end else begin
                            sel_next          = slot;
                            dm_en_next        = 1'b1;
                            dm_in_next        = in_bit;
                            shift_next[slot]  = in_bit;
                            slot_next         = slot + 3'd1;
                            if (slot == 3'd0) begin
                                miss_next = fsync ? 3'd0 : miss_inc;
                            end
                            if (slot == LAST_SLOT) begin
                                frame_next       = {in_bit, shift[6:0]};
                                frame_valid_next = 1'b1;
                                shift_next       = 8'd0;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= 3'd0;
            miss        <= 3'd0;
            shift       <= 8'd0;
            SEL         <= 3'd0;
            dm_en       <= 1'b0;
            dm_in       <= 1'b0;
            frame       <= 8'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_next;
            slot        <= slot_next;
            miss        <= miss_next;
            shift       <= shift_next;
            SEL         <= sel_next;
            dm_en       <= dm_en_next;
            dm_in       <= dm_in_next;
            frame       <= frame_next;
            frame_valid <= frame_valid_next;
            sync_err    <= sync_err_next;
        end
    end

endmodule
